sprite_blitter: RTL

//   Parametrised rectangle/sprite plotter feeding the VGA adapter write port. Accepts a

---
 rtl/bomberman_pkg.sv | 22 ++
 rtl/sprite_blitter_raster_counter.sv | 46 ++++
 rtl/sprite_blitter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomberman video path.
// No logic of its own; blit_state_t encodes the sprite_blitter FSM.
// Backpressure: n/a.
package bomberman_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } blit_state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] COLOUR_BLACK = 3'd0;

    // Counter width for n states, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_blitter_raster_counter.sv
// Column/row raster counter for one SPR_W x SPR_H block; last flags the final pixel.
// Latency: counts advance on the edge where en is high; clear has priority over en.
// Backpressure: holding en low freezes col/row.
module raster_counter
    import bomberman_pkg::*;
#(
    parameter int SPR_W = 4,
    parameter int SPR_H = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       en,
    output logic [cnt_w(SPR_W)-1:0]    col,
    output logic [cnt_w(SPR_H)-1:0]    row,
    output logic                       last
);

    localparam int COL_W = cnt_w(SPR_W);
    localparam int ROW_W = cnt_w(SPR_H);

    logic col_end;
    logic row_end;

    assign col_end = (col == COL_W'(SPR_W - 1));
    assign row_end = (row == ROW_W'(SPR_H - 1));
    assign last    = col_end && row_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite/rectangle plotter: one pixel per cycle in raster order; optional clipping via BLIT_CLIP_EN.
// Latency: first pixel the cycle after accept, done in cycle SPR_W*SPR_H+1, ready back one cycle later.
// Backpressure: stall freezes the raster and drops plot; start is ignored unless ready.
module sprite_blitter
    import bomberman_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SPR_W    = 4,
    parameter int SPR_H    = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                ready,
    input  logic                erase,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic [COLOUR_W-1:0] bg_colour_in,
    input  logic                stall,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                done
);

    localparam int COL_W = cnt_w(SPR_W);
    localparam int ROW_W = cnt_w(SPR_H);

    if (SPR_W < 1 || SPR_H < 1 || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_geometry
        $error("sprite_blitter: block and screen dimensions must be at least 1");
    end

    blit_state_t         state;
    logic [X_W-1:0]      x_base;
    logic [Y_W-1:0]      y_base;
    logic [COLOUR_W-1:0] c_lat;

    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic                last;
    logic                cnt_clear;
    logic                cnt_en;

    logic [X_W-1:0]      x_pix;
    logic [Y_W-1:0]      y_pix;
    logic                pix_on;

    // Counter sits at zero whenever idle, so the accept edge needs no extra clear.
    assign cnt_clear = (state == IDLE);
    assign cnt_en    = (state == DRAW) && !stall;

    raster_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_raster (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .col   (col),
        .row   (row),
        .last  (last)
    );

`ifdef BLIT_CLIP_EN
    // One extra bit so pixels past the right/bottom edge are seen rather than wrapped.
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;

    assign x_sum  = {1'b0, x_base} + (X_W+1)'(col);
    assign y_sum  = {1'b0, y_base} + (Y_W+1)'(row);
    assign x_pix  = x_sum[X_W-1:0];
    assign y_pix  = y_sum[Y_W-1:0];
    assign pix_on = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
`else
    assign x_pix  = x_base + X_W'(col);
    assign y_pix  = y_base + Y_W'(row);
    assign pix_on = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            plot       <= 1'b0;
            done       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= COLOUR_W'(COLOUR_BLACK);
            x_base     <= '0;
            y_base     <= '0;
            c_lat      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start && ready) begin
                        x_base <= x_in;
                        y_base <= y_in;
                        c_lat  <= erase ? bg_colour_in : colour_in;
                        ready  <= 1'b0;
                        state  <= DRAW;
                    end
                end
                DRAW: begin
                    if (stall) begin
                        plot <= 1'b0;
                    end else begin
                        plot       <= pix_on;
                        x_out      <= x_pix;
                        y_out      <= y_pix;
                        colour_out <= c_lat;
                        if (last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle raises done; the second returns to IDLE with ready.
                    plot <= 1'b0;
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    plot  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
